// File: rtl/icache_unit.sv
// Direct-mapped read-only instruction cache. Hits answer in the same cycle.
// Misses refill a whole line with a burst. Uncached fetches do a single-word read.
module icache_unit #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned SETS       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_en,
  input  logic [31:0] ibus_paddr,
  input  logic        ibus_cached,
  output logic [31:0] ibus_rdata,
  output logic        ibus_stallreq,
  input  logic        icache_inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_len,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast
);

  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned IDX_LSB = OFF_W + 2;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_UNC    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];

  logic [IDX_W-1:0] req_idx_q;
  logic [OFF_W-1:0] req_off_q;
  logic [TAG_W-1:0] req_tag_q;
  logic             req_cached_q;
  logic [OFF_W-1:0] beat_q;
  logic [31:0]      resp_q;

  logic [OFF_W-1:0] cur_off;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             hit;
  logic             miss_start;
  logic             beat_fire;
  logic             refill_done;
  logic             unused_paddr;

  assign cur_off      = ibus_paddr[IDX_LSB-1:2];
  assign cur_idx      = ibus_paddr[TAG_LSB-1:IDX_LSB];
  assign cur_tag      = ibus_paddr[31:TAG_LSB];
  assign unused_paddr = ^ibus_paddr[1:0];

  assign hit         = ibus_en & ibus_cached & valid_q[cur_idx] & (tag_mem[cur_idx] == cur_tag);
  assign miss_start  = (state_q == S_IDLE) & ibus_en & ~hit;
  assign beat_fire   = (state_q == S_REFILL) & mem_rvalid;
  assign refill_done = beat_fire & mem_rlast;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and fetch-side outputs; hits bypass the FSM entirely
  always_comb begin
    state_d       = state_q;
    ibus_rdata    = '0;
    ibus_stallreq = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          ibus_rdata = data_mem[{cur_idx, cur_off}];
        end else if (ibus_en) begin
          ibus_stallreq = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        ibus_stallreq = 1'b1;
        if (mem_ack) state_d = req_cached_q ? S_REFILL : S_UNC;
      end
      S_REFILL: begin
        ibus_stallreq = 1'b1;
        if (refill_done) state_d = S_RESP;
      end
      S_UNC: begin
        ibus_stallreq = 1'b1;
        if (mem_rvalid) state_d = S_RESP;
      end
      S_RESP: begin
        if (ibus_en) ibus_rdata = resp_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The fetch stage must not be held while the cache is in reset
    if (rst) begin
      ibus_rdata    = '0;
      ibus_stallreq = 1'b0;
    end
  end

  // Bus request, miss bookkeeping, beat counter and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_len      <= '0;
      beat_q       <= '0;
      valid_q      <= '0;
      req_idx_q    <= '0;
      req_off_q    <= '0;
      req_tag_q    <= '0;
      req_cached_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      mem_req <= (state_d == S_REQ);
      if (miss_start) begin
        mem_addr     <= ibus_cached ? {ibus_paddr[31:IDX_LSB], {IDX_LSB{1'b0}}} : ibus_paddr;
        mem_len      <= ibus_cached ? 4'(LINE_WORDS - 1) : 4'd0;
        beat_q       <= '0;
        req_idx_q    <= cur_idx;
        req_off_q    <= cur_off;
        req_tag_q    <= cur_tag;
        req_cached_q <= ibus_cached;
      end else if (beat_fire) begin
        beat_q <= beat_q + OFF_W'(1);
      end
      if ((beat_fire && (beat_q == req_off_q)) || ((state_q == S_UNC) && mem_rvalid)) begin
        resp_q <= mem_rdata;
      end
      // Invalidate-all takes priority over a completing refill
      if (icache_inv)       valid_q            <= '0;
      else if (refill_done) valid_q[req_idx_q] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (beat_fire)   data_mem[{req_idx_q, beat_q}] <= mem_rdata;
    if (refill_done) tag_mem[req_idx_q]            <= req_tag_q;
  end

endmodule

// File: tb/tb_icache_unit.sv
// Self-checking bench for icache_unit: fetch table with a behavioural memory
// slave, expected words queued at issue and compared when the stall releases.
module tb_icache_unit;

  logic        clk;
  logic        rst;
  logic        ibus_en;
  logic [31:0] ibus_paddr;
  logic        ibus_cached;
  logic [31:0] ibus_rdata;
  logic        ibus_stallreq;
  logic        icache_inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_len;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  icache_unit #(.LINE_WORDS(8), .SETS(64)) dut (
    .clk(clk), .rst(rst),
    .ibus_en(ibus_en), .ibus_paddr(ibus_paddr), .ibus_cached(ibus_cached),
    .ibus_rdata(ibus_rdata), .ibus_stallreq(ibus_stallreq),
    .icache_inv(icache_inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        cached;
    logic        hit;
    logic [31:0] base;
    logic [31:0] exp_data;
    logic [31:0] maddr;
    logic [3:0]  len;
    int          inv_beat;
    int          rst_beat;
  } vec_t;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];
  vec_t        vecs[$];

  function automatic vec_t mk(input logic [31:0] addr, input logic cached, input logic hit,
                              input logic [31:0] base, input logic [31:0] exp_data,
                              input logic [31:0] maddr, input logic [3:0] len,
                              input int inv_beat, input int rst_beat);
    vec_t v;
    v.addr = addr; v.cached = cached; v.hit = hit; v.base = base; v.exp_data = exp_data;
    v.maddr = maddr; v.len = len; v.inv_beat = inv_beat; v.rst_beat = rst_beat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem_inputs();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    mem_rdata  = '0;
    icache_inv = 1'b0;
  endtask

  // One fetch; on a miss this also plays the memory slave (ack on the 3rd req cycle)
  task automatic fetch(input vec_t v);
    int req_cnt;
    int beat;
    bit acked;
    bit just_acked;
    bit done;
    exp_q.push_back(v.exp_data);
    @(negedge clk);
    ibus_en = 1'b1; ibus_paddr = v.addr; ibus_cached = v.cached;
    #1;
    check("first_stall", 32'(ibus_stallreq), 32'(!v.hit));
    if (v.hit) begin
      check("hit_rdata", ibus_rdata, exp_q.pop_front());
      check("hit_no_req", 32'(mem_req), 32'd0);
    end else begin
      req_cnt = 0; beat = 0; acked = 0; just_acked = 0; done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
        @(negedge clk);
        clear_mem_inputs();
        if (!ibus_stallreq) begin
          check("resp_rdata", ibus_rdata, exp_q.pop_front());
          done = 1;
        end else if (acked) begin
          if (just_acked) begin
            check("req_drop", 32'(mem_req), 32'd0);
            just_acked = 0;
          end
          if (beat == v.rst_beat) begin
            rst = 1'b1;
            #1;
            check("rst_req", 32'(mem_req), 32'd0);
            check("rst_stall", 32'(ibus_stallreq), 32'd0);
            @(negedge clk);
            rst = 1'b0; ibus_en = 1'b0;
            void'(exp_q.pop_front());
            done = 1;
          end else if (beat <= int'(v.len)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.base + 32'(beat);
            mem_rlast  = (beat == int'(v.len));
            icache_inv = (beat == v.inv_beat);
            beat++;
          end
        end else if (mem_req) begin
          if (req_cnt == 0) begin
            check("req_addr", mem_addr, v.maddr);
            check("req_len", 32'(mem_len), 32'(v.len));
          end
          req_cnt++;
          if (req_cnt == 3) begin
            mem_ack = 1'b1; acked = 1; just_acked = 1;
          end
        end
      end
      if (!done) begin
        check("resp_timeout", 32'(ibus_stallreq), 32'd0);
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    ibus_en = 1'b0;
    clear_mem_inputs();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; ibus_en = 1'b0; ibus_paddr = '0; ibus_cached = 1'b0;
    clear_mem_inputs();

    vecs.push_back(mk(32'h0000_0104, 1, 0, 32'hA000_0000, 32'hA000_0001, 32'h0000_0100, 4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_011C, 1, 1, 32'h0,         32'hA000_0007, 32'h0,         4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_0100, 1, 1, 32'h0,         32'hA000_0000, 32'h0,         4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_0900, 1, 0, 32'hB000_0000, 32'hB000_0000, 32'h0000_0900, 4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_091C, 1, 1, 32'h0,         32'hB000_0007, 32'h0,         4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_0104, 1, 0, 32'hA000_0010, 32'hA000_0011, 32'h0000_0100, 4'd7, -1, -1));
    vecs.push_back(mk(32'h1FC0_0000, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1FC0_0000, 4'd0, -1, -1));
    vecs.push_back(mk(32'h1FC0_0000, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1FC0_0000, 4'd0, -1, -1));
    vecs.push_back(mk(32'h0000_0108, 1, 1, 32'h0,         32'hA000_0012, 32'h0,         4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_0104, 1, 0, 32'hC000_0000, 32'hC000_0001, 32'h0000_0100, 4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_0204, 1, 0, 32'hD000_0000, 32'hD000_0001, 32'h0000_0200, 4'd7,  7, -1));
    vecs.push_back(mk(32'h0000_0204, 1, 0, 32'hE000_0000, 32'hE000_0001, 32'h0000_0200, 4'd7,  2, -1));
    vecs.push_back(mk(32'h0000_0208, 1, 1, 32'h0,         32'hE000_0002, 32'h0,         4'd7, -1, -1));
    vecs.push_back(mk(32'h0000_0904, 1, 0, 32'hF000_0000, 32'hF000_0001, 32'h0000_0900, 4'd7, -1,  3));
    vecs.push_back(mk(32'h0000_0104, 1, 0, 32'h1234_0000, 32'h1234_0001, 32'h0000_0100, 4'd7, -1, -1));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_len", 32'(mem_len), 32'd0);
    check("reset_stall", 32'(ibus_stallreq), 32'd0);

    foreach (vecs[i]) begin
      if (i == 9) begin
        // Disabled fetch to a resident line, then invalidate everything
        @(negedge clk);
        ibus_en = 1'b0; ibus_paddr = 32'h0000_011C; ibus_cached = 1'b1; icache_inv = 1'b1;
        #1;
        check("idle_rdata", ibus_rdata, 32'd0);
        check("idle_stall", 32'(ibus_stallreq), 32'd0);
        @(negedge clk);
        icache_inv = 1'b0;
      end
      fetch(vecs[i]);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_unit.md
Name: icache_unit

Overview:
- Direct-mapped, read-only instruction cache between the instruction MMU's physical ibus port and the memory bus.
- Hits return the instruction word in the same cycle with no stall.
- Misses to cached addresses refill a full line with a read burst. Uncached fetches perform a single-word read and are not allocated.
- Stalls the fetch stage through ibus_stallreq until the word is available.

Parameters:
- LINE_WORDS, 8, words per line (power of 2, 2..16); offset field = paddr[log2(LINE_WORDS)+1:2]
- SETS, 64, number of lines (power of 2); index field sits above offset; tag = remaining upper bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ibus_en  in  1  fetch request valid this cycle
- ibus_paddr  in  32  physical fetch address, word aligned; held stable while ibus_stallreq=1
- ibus_cached  in  1  1 = cacheable (kseg0/useg), 0 = uncached (kseg1)
- ibus_rdata  out  32  instruction word; valid when ibus_en=1 and ibus_stallreq=0
- ibus_stallreq  out  1  fetch must hold
- icache_inv  in  1  one-cycle pulse: invalidate all lines
- mem_req  out  1  read request; held until mem_ack
- mem_addr  out  32  line-aligned address for a refill, exact word address for an uncached read
- mem_len  out  4  beats minus 1 (LINE_WORDS-1 for refill, 0 for uncached)
- mem_ack  in  1  request accepted this cycle
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat data
- mem_rlast  in  1  final beat of the burst

Behaviour:
- Storage: per line, a valid bit (register array, async reset to 0), a tag, and LINE_WORDS data words.
- Hit = ibus_en & ibus_cached & valid[index] & (tag match), evaluated combinationally in IDLE.
- Reset values: state IDLE, all valid=0, mem_req=0, mem_addr=0, mem_len=0, beat counter=0.
- ibus_en=0: ibus_rdata=0, ibus_stallreq=0; no state change except invalidation.
- IDLE:
  - Hit: ibus_rdata = line word, stall=0.
  - Cached miss: stall=1; next edge → REQ with mem_addr = {paddr[31:offset+2], 0}, mem_len = LINE_WORDS-1.
  - Uncached: stall=1; next edge → REQ with mem_addr = paddr, mem_len=0.
- REQ: mem_req=1, stall=1. On mem_ack → REFILL (cached) or UNC (uncached); mem_req drops the next cycle.
- REFILL: stall=1.
  - Beats arrive in ascending word order from offset 0; each mem_rvalid writes word[counter], counter++.
  - On mem_rlast: write the tag, set valid, → RESP. The requested word is captured as it streams in.
- UNC: stall=1; on mem_rvalid latch mem_rdata into the response register → RESP. No array write.
- RESP (exactly 1 cycle): ibus_rdata = response register, stall=0; → IDLE. The fetch stage advances this cycle.
- Bus rules:
  - mem_rvalid is never sent before the cycle after mem_ack.
  - mem_rvalid outside REFILL/UNC is ignored.
  - mem_rlast without the full beat count still completes the refill; missing words are undefined (slave bug).
- icache_inv: clears all valid bits at the next edge, in any state.
  - Same edge as a refill's rlast: inv wins, the line stays invalid, and the response is still delivered.
  - Inv during earlier refill beats: the refilled line becomes valid at rlast.
- rst mid-transaction: immediate return to IDLE, mem_req=0, all lines invalid. The memory slave shares rst, so the abandoned burst is discarded.
- Address change while stalled is illegal; behaviour is undefined.

Test Plan:
- Reset, then fetch cached 0x0000_0104:
  - ibus_stallreq=1; mem_req with mem_addr=0x0000_0100, mem_len=7.
  - mem_ack 2 cycles later; beats 0xA000_0000..0xA000_0007.
  - RESP cycle gives ibus_rdata=0xA000_0001 with stall=0.
- Then fetch 0x0000_011C → same-cycle hit, ibus_rdata=0xA000_0007, stall=0, no mem_req.
- Fetch 0x0000_0900 (index 8, different tag) → miss, refill at 0x900. A subsequent 0x0000_0104 misses again (line evicted).
- Uncached 0x1FC0_0000 (ibus_cached=0) → mem_len=0, single beat 0xDEADBEEF returned in RESP. Refetching the same address misses again.
- After test 1, pulse icache_inv, then fetch 0x0000_0104 → miss, new mem_req.
- Assert rst during beat 3 of a refill → mem_req=0 and stall=0 immediately. After release, 0x0000_0104 misses.
- icache_inv on the same edge as mem_rlast → response delivered, the next fetch to that line misses.
